// File: rtl/tri_chan_delay_pipe.sv
// Three independent delay lines (a->d, b->e, c->f) with programmable latency,
// a shared advance enable and synchronous flush. Each pipe is a shift
// register of {vld, data} stages whose last stage drives the outputs, so
// every output is registered. Bubbles shift zero data so idle outputs read 0.
module tri_chan_delay_pipe #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LAT_D = 1,
  parameter int unsigned LAT_E = 2,
  parameter int unsigned LAT_F = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic             d_vld,
  output logic             e_vld,
  output logic             f_vld,
  output logic             all_vld,
  output logic             busy,
  output logic [7:0]       f_cnt
);

  // Out-of-range latencies stop elaboration.
  if (LAT_D < 1 || LAT_D > 16) begin : g_bad_lat_d
    $error("tri_chan_delay_pipe: LAT_D must be in 1..16");
  end
  if (LAT_E < 1 || LAT_E > 16) begin : g_bad_lat_e
    $error("tri_chan_delay_pipe: LAT_E must be in 1..16");
  end
  if (LAT_F < 1 || LAT_F > 16) begin : g_bad_lat_f
    $error("tri_chan_delay_pipe: LAT_F must be in 1..16");
  end

  // Stage 0 is the input side; stage LAT_x-1 drives the output.
  logic [LAT_D-1:0]            d_vld_q;
  logic [LAT_D-1:0][WIDTH-1:0] d_dat_q;
  logic [LAT_E-1:0]            e_vld_q;
  logic [LAT_E-1:0][WIDTH-1:0] e_dat_q;
  logic [LAT_F-1:0]            f_vld_q;
  logic [LAT_F-1:0][WIDTH-1:0] f_dat_q;
  logic [7:0]                  f_cnt_q;

  // Only an enabled, non-flushing edge moves the pipes forward.
  logic advance;
  assign advance = en & ~flush;

  // Channel A -> d shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_vld_q <= '0;
      d_dat_q <= '0;
    end else if (flush) begin
      d_vld_q <= '0;
      d_dat_q <= '0;
    end else if (advance) begin
      d_vld_q[0] <= in_valid;
      d_dat_q[0] <= in_valid ? a : '0;
      for (int k = 1; k < int'(LAT_D); k++) begin
        d_vld_q[k] <= d_vld_q[k-1];
        d_dat_q[k] <= d_dat_q[k-1];
      end
    end
  end

  // Channel B -> e shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_vld_q <= '0;
      e_dat_q <= '0;
    end else if (flush) begin
      e_vld_q <= '0;
      e_dat_q <= '0;
    end else if (advance) begin
      e_vld_q[0] <= in_valid;
      e_dat_q[0] <= in_valid ? b : '0;
      for (int k = 1; k < int'(LAT_E); k++) begin
        e_vld_q[k] <= e_vld_q[k-1];
        e_dat_q[k] <= e_dat_q[k-1];
      end
    end
  end

  // Channel C -> f shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_vld_q <= '0;
      f_dat_q <= '0;
    end else if (flush) begin
      f_vld_q <= '0;
      f_dat_q <= '0;
    end else if (advance) begin
      f_vld_q[0] <= in_valid;
      f_dat_q[0] <= in_valid ? c : '0;
      for (int k = 1; k < int'(LAT_F); k++) begin
        f_vld_q[k] <= f_vld_q[k-1];
        f_dat_q[k] <= f_dat_q[k-1];
      end
    end
  end

  // Count f samples as they leave the output stage; wraps freely at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_cnt_q <= 8'd0;
    end else if (flush) begin
      f_cnt_q <= 8'd0;
    end else if (advance && f_vld_q[LAT_F-1]) begin
      f_cnt_q <= f_cnt_q + 8'd1;
    end
  end

  assign d       = d_dat_q[LAT_D-1];
  assign e       = e_dat_q[LAT_E-1];
  assign f       = f_dat_q[LAT_F-1];
  assign d_vld   = d_vld_q[LAT_D-1];
  assign e_vld   = e_vld_q[LAT_E-1];
  assign f_vld   = f_vld_q[LAT_F-1];
  assign all_vld = d_vld & e_vld & f_vld;
  assign busy    = (|d_vld_q) | (|e_vld_q) | (|f_vld_q);
  assign f_cnt   = f_cnt_q;

endmodule

// File: tb/tb_tri_chan_delay_pipe.sv
// Bench for tri_chan_delay_pipe: directed stimulus pushes expected outputs
// (data plus the enabled-edge number at which they must appear) into
// per-channel queues; a monitor pops and checks on every advancing edge.
module tb_tri_chan_delay_pipe;
  localparam int W  = 3;
  localparam int LD = 1;
  localparam int LE = 2;
  localparam int LF = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] c = '0;
  logic [W-1:0] d, e, f;
  logic         d_vld, e_vld, f_vld, all_vld, busy;
  logic [7:0]   f_cnt;

  tri_chan_delay_pipe #(
    .WIDTH (W),
    .LAT_D (LD),
    .LAT_E (LE),
    .LAT_F (LF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .d_vld    (d_vld),
    .e_vld    (e_vld),
    .f_vld    (f_vld),
    .all_vld  (all_vld),
    .busy     (busy),
    .f_cnt    (f_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t qd[$];
  exp_t qe[$];
  exp_t qf[$];

  int   total = 0;
  int   bad = 0;
  int   ecnt = 0;      // number of advancing edges so far
  int   exp_fcnt = 0;
  logic fvld_seen = 1'b0;
  logic adv;

  task automatic cmp(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, req, ecnt);
    end
  endtask

  function automatic int qsize(input int ch);
    case (ch)
      0:       return qd.size();
      1:       return qe.size();
      default: return qf.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int ch);
    case (ch)
      0:       return qd[0];
      1:       return qe[0];
      default: return qf[0];
    endcase
  endfunction

  task automatic qpop(input int ch, output exp_t it);
    case (ch)
      0:       it = qd.pop_front();
      1:       it = qe.pop_front();
      default: it = qf.pop_front();
    endcase
  endtask

  task automatic qclear();
    qd.delete();
    qe.delete();
    qf.delete();
  endtask

  task automatic check_chan(input int ch, input string nm, input logic v, input logic [W-1:0] dat);
    exp_t it;
    if (v) begin
      total++;
      if (qsize(ch) == 0) begin
        bad++;
        $display("FAIL %s_unexpected: got data %0d expected no output (edge %0d)", nm, dat, ecnt);
      end else begin
        qpop(ch, it);
        if (dat != it.data || it.due != ecnt) begin
          bad++;
          $display("FAIL %s_data: got %0d at edge %0d expected %0d at edge %0d",
                   nm, dat, ecnt, it.data, it.due);
        end
      end
    end else begin
      cmp({nm, "_idle_zero"}, int'(dat), 0);
      if (qsize(ch) != 0 && qfront(ch).due <= ecnt) begin
        qpop(ch, it);
        total++;
        bad++;
        $display("FAIL %s_missing: got no output expected %0d due edge %0d", nm, it.data, it.due);
      end
    end
  endtask

  // Monitor: on each advancing edge, pop and compare outputs.
  initial begin
    forever begin
      @(posedge clk);
      adv = en && !flush && !reset;
      if (reset || flush) exp_fcnt = 0;
      else if (adv && fvld_seen) exp_fcnt = (exp_fcnt + 1) % 256;
      if (adv) ecnt++;
      #1;
      if (adv) begin
        check_chan(0, "d", d_vld, d);
        check_chan(1, "e", e_vld, e);
        check_chan(2, "f", f_vld, f);
      end
      cmp("f_cnt_model", int'(f_cnt), exp_fcnt);
      fvld_seen = f_vld;
    end
  end

  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] z, input logic en_in, input logic fl);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    c        = z;
    en       = en_in;
    flush    = fl;
    if (fl) qclear();
    else if (v && en_in) begin
      qd.push_back('{data: x, due: ecnt + LD});
      qe.push_back('{data: y, due: ecnt + LE});
      qf.push_back('{data: z, due: ecnt + LF});
    end
    @(posedge clk);
    #2;
  endtask

  logic [W-1:0] val;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cmp("rst_d", int'(d), 0);
    cmp("rst_vld", int'({d_vld, e_vld, f_vld}), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_fcnt", int'(f_cnt), 0);

    // Single sample with default latencies; bubble data is nonzero on purpose
    step(1'b1, 3'd4, 3'd5, 3'd6, 1'b1, 1'b0);
    cmp("single_d1", int'(d), 4);
    cmp("single_dvld1", int'(d_vld), 1);
    cmp("single_evld1", int'(e_vld), 0);
    step(1'b0, 3'd7, 3'd7, 3'd7, 1'b1, 1'b0);
    cmp("single_e2", int'(e), 5);
    cmp("single_evld2", int'(e_vld), 1);
    cmp("single_d2", int'(d), 0);
    cmp("single_dvld2", int'(d_vld), 0);
    step(1'b0, 3'd7, 3'd7, 3'd7, 1'b1, 1'b0);
    cmp("single_f3", int'(f), 6);
    cmp("single_fvld3", int'(f_vld), 1);
    cmp("single_allvld3", int'(all_vld), 0);
    cmp("single_busy3", int'(busy), 1);
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    cmp("single_busy4", int'(busy), 0);
    cmp("single_fcnt4", int'(f_cnt), 1);

    // Streaming after a flush
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    cmp("stream_fcnt0", int'(f_cnt), 0);
    for (int k = 1; k <= 8; k++) begin
      val = k[W-1:0];
      step(1'b1, val, val, val, 1'b1, 1'b0);
      cmp("stream_d", int'(d), k % 8);
      if (k >= 2) cmp("stream_e", int'(e), (k - 1) % 8);
      if (k >= 3) begin
        cmp("stream_f", int'(f), (k - 2) % 8);
        cmp("stream_allvld", int'(all_vld), 1);
      end else begin
        cmp("stream_allvld_early", int'(all_vld), 0);
      end
      if (k == 8) cmp("stream_fcnt5", int'(f_cnt), 5);
    end

    // Asynchronous reset with pipes full, checked before the next edge
    @(negedge clk);
    reset = 1'b1;
    #1;
    cmp("arst_def", int'({d, e, f}), 0);
    cmp("arst_vld", int'({d_vld, e_vld, f_vld}), 0);
    cmp("arst_busy", int'(busy), 0);
    cmp("arst_fcnt", int'(f_cnt), 0);
    qclear();
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (4) step(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    cmp("arst_nothing_left", int'(busy), 0);

    // Stall: outputs freeze, stalled edges do not count toward latency
    step(1'b1, 3'd4, 3'd5, 3'd6, 1'b1, 1'b0);
    cmp("stall_d_acc", int'(d), 4);
    repeat (4) begin
      step(1'b1, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0);
      cmp("stall_d_hold", int'(d), 4);
      cmp("stall_dvld_hold", int'(d_vld), 1);
      cmp("stall_evld_hold", int'(e_vld), 0);
      cmp("stall_busy", int'(busy), 1);
    end
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    cmp("stall_e", int'(e), 5);
    cmp("stall_evld", int'(e_vld), 1);
    cmp("stall_dvld_after", int'(d_vld), 0);
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    cmp("stall_f", int'(f), 6);
    cmp("stall_fvld", int'(f_vld), 1);

    // Flush overrides en and discards the input of that cycle
    for (int k = 1; k <= 3; k++) begin
      val = k[W-1:0];
      step(1'b1, val, val, val, 1'b1, 1'b0);
    end
    step(1'b1, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1);
    cmp("flush_vld", int'({d_vld, e_vld, f_vld}), 0);
    cmp("flush_busy", int'(busy), 0);
    cmp("flush_fcnt", int'(f_cnt), 0);
    cmp("flush_d", int'(d), 0);
    step(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    cmp("flush_no7_dvld", int'(d_vld), 0);
    cmp("flush_no7_busy", int'(busy), 0);

    // Counter wrap: 258 valid samples
    for (int k = 1; k <= 262; k++) begin
      val = k[W-1:0];
      step(k <= 258, val, val, val, 1'b1, 1'b0);
      if (k == 258) cmp("wrap_fcnt255", int'(f_cnt), 255);
      if (k == 259) begin
        cmp("wrap_fcnt0", int'(f_cnt), 0);
        cmp("wrap_fvld", int'(f_vld), 1);
      end
      if (k == 260) cmp("wrap_fcnt1", int'(f_cnt), 1);
    end
    repeat (2) step(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    cmp("drain_busy", int'(busy), 0);
    cmp("drain_queues", qd.size() + qe.size() + qf.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
